fifo_write_arbiter: RTL and testbench
=====================================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, meaning the width of each requester's data word and of push_data.
REQ-002 The block SHALL have parameter BURST_MAX, default 4, meaning the maximum words granted to one requester per tenure; legal range 1..15.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 req0  input  1  requester 0 has a valid word on data0.
REQ-007 data0  input  DATA_W  requester 0 write word.
REQ-008 req1  input  1  requester 1 has a valid word on data1.
REQ-009 data1  input  DATA_W  requester 1 write word.
REQ-010 full  input  1  FIFO full flag, write side.
REQ-011 gnt0  output  1  requester 0 word is transferred on this edge.
REQ-012 gnt1  output  1  requester 1 word is transferred on this edge.
REQ-013 push  output  1  FIFO write strobe.
REQ-014 push_data  output  DATA_W  FIFO write word.
REQ-015 owner  output  2  current tenure: 00 none, 01 requester 0, 10 requester 1.
REQ-016 words_pushed  output  8  running count of accepted pushes, wraps 255->0.

Function
REQ-017 FSM states SHALL be IDLE, SERVE0, SERVE1; owner SHALL be decoded from the state.
REQ-018 In IDLE, no push; with full=0, the next state SHALL be: only req0 -> SERVE0; only req1 -> SERVE1; both -> the requester not equal to last_served. With full=1 or no req, the FSM SHALL stay in IDLE.
REQ-019 gnt0 SHALL be combinational: (state==SERVE0) && req0 && !full. gnt1 is the same for SERVE1 and req1.
REQ-020 push SHALL equal gnt0|gnt1. push_data SHALL be data0 when gnt0, data1 when gnt1, and zero otherwise.
REQ-021 A transfer is a rising edge with gnt asserted. The requester SHALL present its next word or drop req on that same edge. Grant latency from IDLE SHALL be 1 cycle.
REQ-022 The burst counter SHALL increment on each transfer and SHALL be cleared on any exit from SERVEx.
REQ-023 A tenure SHALL end, with a transition to IDLE at the next edge and last_served updated to that requester, when either condition holds:
  - a transfer occurs with burst counter == BURST_MAX-1;
  - req of the owner is low while in SERVEx.
REQ-024 full=1 in SERVEx SHALL stall the tenure: no grant, no count, state held.
REQ-025 Every tenure SHALL be followed by at least one IDLE cycle (one-cycle bubble), giving round-robin alternation under contention.
REQ-026 words_pushed SHALL increment by 1 on every edge where push=1.
REQ-027 gnt0 and gnt1 SHALL never be asserted together.

Reset
REQ-028 On rst=1 at an edge, the block SHALL set:
  - state to IDLE;
  - last_served to requester 1, so that requester 0 wins the first contention;
  - the burst counter to 0;
  - words_pushed to 0.
REQ-029 While rst=1, gnt0, gnt1 and push SHALL be 0, push_data SHALL be 0, and owner SHALL be 00. Reset mid-burst SHALL abort the burst with no push on the reset cycle.

Structure
REQ-030 The state encoding and the owner encoding SHALL be defined in a shared package, fifo_arb_pkg, together with DATA_W default and the counter widths.
REQ-031 The block SHALL be a single module with no sub-modules; the round-robin pick SHALL be inline logic.

Verification
REQ-032 Reset, then req0=1 holding data0=3,4,5,6,7: gnt0 SHALL be high on cycles 2-5; words 3,4,5,6 SHALL be pushed; IDLE on cycle 6; 7 SHALL be pushed in the next tenure.
REQ-033 req0 and req1 both continuously high, BURST_MAX=4: pushes SHALL be 4 from requester 0, a bubble, 4 from requester 1, and alternating thereafter.
REQ-034 full=1 asserted mid-tenure after 2 words for 3 cycles: push=0 for those 3 cycles, owner unchanged, then the remaining 2 words SHALL be pushed.
REQ-035 req1 alone, then dropped after 1 word: IDLE on the next cycle; a subsequent simultaneous req0 and req1 SHALL be granted to requester 0.
REQ-036 rst asserted during SERVE1 after 2 words: outputs SHALL be zero on the same cycle, words_pushed SHALL be 0 after the edge, and the next contention SHALL go to requester 0.
REQ-037 After 256 pushes, words_pushed SHALL read 0; push and gnt SHALL never assert while full=1.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// ==== fifo_arb_pkg : shared encodings for fifo_write_arbiter ==== rev 1.0
`default_nettype none

package fifo_arb_pkg;

   localparam int DATA_W_DEF = 4;
   localparam int BURST_W    = 4;
   localparam int WORDS_W    = 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SERVE0 = 2'd1;
   localparam logic [1:0] ST_SERVE1 = 2'd2;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_REQ0 = 2'b01;
   localparam logic [1:0] OWN_REQ1 = 2'b10;

   function automatic logic [1:0] owner_of(input logic [1:0] st);
      case (st)
         ST_SERVE0: owner_of = OWN_REQ0;
         ST_SERVE1: owner_of = OWN_REQ1;
         default:   owner_of = OWN_NONE;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
// ==== fifo_write_arbiter : two-requester burst round-robin FIFO write arbiter ==== rev 1.0
`default_nettype none

module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int BURST_MAX = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [DATA_W-1:0] data0,
   input  logic              req1,
   input  logic [DATA_W-1:0] data1,
   input  logic              full,
   output logic              gnt0,
   output logic              gnt1,
   output logic              push,
   output logic [DATA_W-1:0] push_data,
   output logic [1:0]        owner,
   output logic [7:0]        words_pushed
);

   logic [1:0]         state_q, state_d;
   logic               last1_q, last1_d;   // 1 => requester 1 was served last
   logic [BURST_W-1:0] burst_q, burst_d;
   logic [WORDS_W-1:0] words_q;

   logic xfer0, xfer1, burst_last;

   // Grants are gated by rst so a burst in flight is cut off on the reset cycle.
   assign xfer0      = !rst && (state_q == ST_SERVE0) && req0 && !full;
   assign xfer1      = !rst && (state_q == ST_SERVE1) && req1 && !full;
   assign burst_last = (burst_q == BURST_W'(BURST_MAX - 1));

   always_comb begin
      state_d = state_q;
      last1_d = last1_q;
      burst_d = burst_q;
      case (state_q)
         ST_IDLE: begin
            if (!full) begin
               if (req0 && (!req1 || last1_q))
                  state_d = ST_SERVE0;
               else if (req1)
                  state_d = ST_SERVE1;
            end
         end
         ST_SERVE0: begin
            if (!req0 || (xfer0 && burst_last)) begin
               state_d = ST_IDLE;
               last1_d = 1'b0;
               burst_d = '0;
            end else if (xfer0) begin
               burst_d = burst_q + 1'b1;
            end
         end
         ST_SERVE1: begin
            if (!req1 || (xfer1 && burst_last)) begin
               state_d = ST_IDLE;
               last1_d = 1'b1;
               burst_d = '0;
            end else if (xfer1) begin
               burst_d = burst_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            burst_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         last1_q <= 1'b1;
         burst_q <= '0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         last1_q <= last1_d;
         burst_q <= burst_d;
         if (xfer0 || xfer1)
            words_q <= words_q + 1'b1;
      end
   end

   assign gnt0         = xfer0;
   assign gnt1         = xfer1;
   assign push         = xfer0 | xfer1;
   assign push_data    = xfer0 ? data0 : (xfer1 ? data1 : '0);
   assign owner        = rst ? OWN_NONE : owner_of(state_q);
   assign words_pushed = words_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// ==== tb_fifo_write_arbiter : directed self-checking bench for fifo_write_arbiter ==== rev 1.0
`default_nettype none

module tb_fifo_write_arbiter;

   logic       clk = 1'b0;
   logic       rst, req0, req1, full;
   logic [3:0] data0, data1;
   logic       gnt0, gnt1, push;
   logic [3:0] push_data;
   logic [1:0] owner;
   logic [7:0] words_pushed;

   int n_vec = 0;
   int n_err = 0;

   fifo_write_arbiter #(.DATA_W(4), .BURST_MAX(4)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req0         (req0),
      .data0        (data0),
      .req1         (req1),
      .data1        (data1),
      .full         (full),
      .gnt0         (gnt0),
      .gnt1         (gnt1),
      .push         (push),
      .push_data    (push_data),
      .owner        (owner),
      .words_pushed (words_pushed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Check one cycle's outputs against expected grant code, owner and word, then advance.
   task automatic cyc(input string tag, input logic [1:0] eg, input logic [1:0] eo,
                      input logic [3:0] ed);
      #1;
      chk({tag, ".gnt"},   {30'd0, gnt1, gnt0}, {30'd0, eg});
      chk({tag, ".push"},  {31'd0, push},       {31'd0, |eg});
      chk({tag, ".owner"}, {30'd0, owner},      {30'd0, eo});
      chk({tag, ".data"},  {28'd0, push_data},  {28'd0, ed});
      tick();
   endtask

   task automatic do_reset;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; full = 1'b0; data0 = '0; data1 = '0;
      tick();
      chk("rst.words", {24'd0, words_pushed}, 32'd0);
      chk("rst.owner", {30'd0, owner}, 32'd0);
      chk("rst.push",  {31'd0, push}, 32'd0);
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] eg;
      logic [1:0] eo;

      // Single requester, burst of 4, bubble, then the 5th word in a new tenure
      do_reset();
      req0 = 1'b1; data0 = 4'd3;
      for (int c = 1; c <= 7; c++) begin
         eg = ((c >= 2 && c <= 5) || c == 7) ? 2'b01 : 2'b00;
         eo = (c == 1 || c == 6) ? 2'b00 : 2'b01;
         cyc("A", eg, eo, eg[0] ? data0 : 4'd0);
         if (eg[0]) data0 = data0 + 4'd1;
         if (c == 7) req0 = 1'b0;
      end
      #1;
      chk("A.words", {24'd0, words_pushed}, 32'd5);
      chk("A.gnt_drop", {30'd0, gnt1, gnt0}, 32'd0);
      tick();
      chk("A.idle", {30'd0, owner}, 32'd0);

      // Continuous contention: 4 from req0, bubble, 4 from req1, bubble, 4 from req0
      do_reset();
      req0 = 1'b1; req1 = 1'b1; data0 = 4'hA; data1 = 4'h5;
      for (int c = 1; c <= 15; c++) begin
         if (c >= 2 && c <= 5)        eg = 2'b01;
         else if (c >= 7 && c <= 10)  eg = 2'b10;
         else if (c >= 12)            eg = 2'b01;
         else                         eg = 2'b00;
         cyc("B", eg, eg, eg[0] ? 4'hA : (eg[1] ? 4'h5 : 4'h0));
      end

      // full stalls mid-tenure for 3 cycles, owner held, remaining 2 words follow
      do_reset();
      req0 = 1'b1; data0 = 4'd1;
      for (int c = 1; c <= 9; c++) begin
         full = (c >= 4 && c <= 6);
         eg   = (c == 2 || c == 3 || c == 7 || c == 8) ? 2'b01 : 2'b00;
         eo   = (c == 1 || c == 9) ? 2'b00 : 2'b01;
         cyc("C", eg, eo, eg[0] ? data0 : 4'd0);
         if (eg[0]) data0 = data0 + 4'd1;
      end
      full = 1'b0;

      // req1 drops after one word; next contention goes to req0
      do_reset();
      req1 = 1'b1; data1 = 4'd7;
      cyc("D1", 2'b00, 2'b00, 4'd0);
      cyc("D2", 2'b10, 2'b10, 4'd7);
      req1 = 1'b0;
      cyc("D3", 2'b00, 2'b10, 4'd0);
      req0 = 1'b1; req1 = 1'b1; data0 = 4'd2; data1 = 4'd8;
      cyc("D4", 2'b00, 2'b00, 4'd0);
      cyc("D5", 2'b01, 2'b01, 4'd2);

      // reset during SERVE1 after 2 words
      do_reset();
      req1 = 1'b1; data1 = 4'd9;
      cyc("E1", 2'b00, 2'b00, 4'd0);
      cyc("E2", 2'b10, 2'b10, 4'd9);
      data1 = 4'd10;
      cyc("E3", 2'b10, 2'b10, 4'd10);
      data1 = 4'd11;
      rst = 1'b1;
      #1;
      chk("E.rst_gnt",   {30'd0, gnt1, gnt0}, 32'd0);
      chk("E.rst_push",  {31'd0, push}, 32'd0);
      chk("E.rst_data",  {28'd0, push_data}, 32'd0);
      chk("E.rst_owner", {30'd0, owner}, 32'd0);
      tick();
      rst = 1'b0; req0 = 1'b1; data0 = 4'd6;
      chk("E.words", {24'd0, words_pushed}, 32'd0);
      cyc("E4", 2'b00, 2'b00, 4'd0);
      cyc("E5", 2'b01, 2'b01, 4'd6);

      // 256 pushes wrap the counter; then nothing may push while full
      do_reset();
      req0 = 1'b1; data0 = 4'd5;
      for (int c = 1; c <= 321; c++) begin
         #1;
         chk("F.push", {31'd0, push}, {31'd0, (c >= 2) && (((c - 2) % 5) < 4)});
         if (c == 161) chk("F.half", {24'd0, words_pushed}, 32'd128);
         tick();
      end
      #1;
      chk("F.wrap", {24'd0, words_pushed}, 32'd0);
      full = 1'b1; req1 = 1'b1;
      for (int c = 0; c < 20; c++) begin
         #1;
         chk("F.full_push", {31'd0, push}, 32'd0);
         chk("F.full_gnt", {30'd0, gnt1, gnt0}, 32'd0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
